// File: rtl/line_counter_pkg.sv
// ---------------------------------------------------------------------------
// line_counter_pkg
// Shared definitions for the vertical timing stage.
// The state encodings are shared with the horizontal pixel stage, which will
// reuse them when its FSM is rewritten.
// The default line-index width lives here so the counter and the
// configuration checker agree on it.
// No ports (package).
// ---------------------------------------------------------------------------
package line_counter_pkg;

    // Fixed 3-bit encodings so that both timing stages decode states identically.
    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_FRONT  = 3'd2,
        ST_SYNC   = 3'd3,
        ST_BACK   = 3'd4
    } state_t;

    localparam int LINE_W = 10;

endpackage

// File: rtl/timing_cfg_check.sv
// ---------------------------------------------------------------------------
// timing_cfg_check
// Purely combinational validity check for a set of timing thresholds.
// A configuration is usable only when the regions are non-empty and ordered:
// 0 < s_blank < s_sync < r_sync <= last.
// The horizontal stage can reuse this checker with its own widths.
//
// Ports:
//   i_s_blank  first index of blanking
//   i_s_sync   first index of sync
//   i_r_sync   first index after sync
//   i_last     final index of the period
//   o_valid    high when the thresholds form a usable configuration
// ---------------------------------------------------------------------------
module timing_cfg_check
    import line_counter_pkg::*;
#(
    parameter int c = LINE_W
) (
    input  logic [c-1:0] i_s_blank,
    input  logic [c-1:0] i_s_sync,
    input  logic [c-1:0] i_r_sync,
    input  logic [c-1:0] i_last,
    output logic         o_valid
);

    // An active region of zero lines, or any out-of-order threshold, is rejected.
    assign o_valid = (i_s_blank != '0)
                   && (i_s_blank < i_s_sync)
                   && (i_s_sync  < i_r_sync)
                   && (i_r_sync  <= i_last);

endmodule

// File: rtl/line_counter.sv
// ---------------------------------------------------------------------------
// line_counter
// Vertical timing stage. It counts line-end strobes from the horizontal stage
// and produces the line index, vertical blank, vertical sync and a one-cycle
// end-of-frame pulse. Thresholds are latched into shadow registers only at
// frame boundaries, so a mid-frame change cannot tear the raster.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_line_end   one-cycle strobe on the last pixel of each line
//   i_s_blank    first line of vertical blanking
//   i_s_sync     first line of vertical sync
//   i_r_sync     first line after vertical sync
//   i_last       final line of the frame
//   o_q          current line index
//   o_blank      vertical blank level
//   o_sync       vertical sync level, active-high
//   o_frame_end  one-cycle pulse when the index wraps from last to 0
//   o_cfg_err    set when the last sampled configuration was invalid
// ---------------------------------------------------------------------------
module line_counter
    import line_counter_pkg::*;
#(
    parameter int c = LINE_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_line_end,
    input  logic [c-1:0] i_s_blank,
    input  logic [c-1:0] i_s_sync,
    input  logic [c-1:0] i_r_sync,
    input  logic [c-1:0] i_last,
    output logic [c-1:0] o_q,
    output logic         o_blank,
    output logic         o_sync,
    output logic         o_frame_end,
    output logic         o_cfg_err
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [c-1:0] r_q;
    logic [c-1:0] w_q_nxt;
    logic [c-1:0] w_q_inc;
    logic [c-1:0] r_sh_blank;
    logic [c-1:0] r_sh_sync;
    logic [c-1:0] r_sh_rsync;
    logic [c-1:0] r_sh_last;
    logic         r_blank;
    logic         r_sync;
    logic         r_frame_end;
    logic         r_cfg_err;
    logic         w_valid;
    logic         w_sample;
    logic         w_wrap;
    logic         w_cfg_err_nxt;
    logic         w_blank_nxt;
    logic         w_sync_nxt;

    // The live inputs are checked, because they are what gets latched.
    timing_cfg_check #(
        .c (c)
    ) u_cfg_check (
        .i_s_blank (i_s_blank),
        .i_s_sync  (i_s_sync),
        .i_r_sync  (i_r_sync),
        .i_last    (i_last),
        .o_valid   (w_valid)
    );

    assign w_q_inc = r_q + {{(c-1){1'b0}}, 1'b1};

    // Next-state logic.
    // INIT only samples the configuration and never moves the index.
    // A running frame either advances the index or, on the final line, wraps
    // and resamples. The region transitions look at the incremented index so
    // that the state always matches the new index.
    always_comb begin
        w_state_nxt   = r_state;
        w_q_nxt       = r_q;
        w_sample      = 1'b0;
        w_wrap        = 1'b0;
        w_cfg_err_nxt = r_cfg_err;
        if (i_line_end) begin
            if (r_state == ST_INIT) begin
                w_sample = 1'b1;
                w_q_nxt  = '0;
                if (w_valid) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_cfg_err_nxt = 1'b0;
                end else begin
                    w_cfg_err_nxt = 1'b1;
                end
            end else if (r_q == r_sh_last) begin
                w_wrap   = 1'b1;
                w_sample = 1'b1;
                w_q_nxt  = '0;
                if (w_valid) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_cfg_err_nxt = 1'b0;
                end else begin
                    w_state_nxt   = ST_INIT;
                    w_cfg_err_nxt = 1'b1;
                end
            end else begin
                w_q_nxt = w_q_inc;
                case (r_state)
                    ST_ACTIVE: if (w_q_inc == r_sh_blank) w_state_nxt = ST_FRONT;
                    ST_FRONT:  if (w_q_inc == r_sh_sync)  w_state_nxt = ST_SYNC;
                    ST_SYNC:   if (w_q_inc == r_sh_rsync) w_state_nxt = ST_BACK;
                    default:   w_state_nxt = r_state;
                endcase
            end
        end
    end

    // Output decode from the upcoming state, so that the registered outputs
    // line up with the registered index on the same edge.
    always_comb begin
        w_blank_nxt = (w_state_nxt != ST_ACTIVE);
        w_sync_nxt  = (w_state_nxt == ST_SYNC);
    end

    // State, counter, shadow and output registers.
    // Reset drops straight back to INIT with blanking asserted. No end-of-frame
    // pulse is produced by a reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_INIT;
            r_q         <= '0;
            r_sh_blank  <= '0;
            r_sh_sync   <= '0;
            r_sh_rsync  <= '0;
            r_sh_last   <= '0;
            r_blank     <= 1'b1;
            r_sync      <= 1'b0;
            r_frame_end <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_q         <= w_q_nxt;
            r_blank     <= w_blank_nxt;
            r_sync      <= w_sync_nxt;
            r_frame_end <= w_wrap;
            r_cfg_err   <= w_cfg_err_nxt;
            if (w_sample) begin
                r_sh_blank <= i_s_blank;
                r_sh_sync  <= i_s_sync;
                r_sh_rsync <= i_r_sync;
                r_sh_last  <= i_last;
            end
        end
    end

    assign o_q         = r_q;
    assign o_blank     = r_blank;
    assign o_sync      = r_sync;
    assign o_frame_end = r_frame_end;
    assign o_cfg_err   = r_cfg_err;

endmodule
